// File: rtl/sc_game_flow_fsm.sv
// Frogger main game-flow controller: start/play/pause/dying/level-up/end sequencing
// with lives and level counters and timed respawn and level-up interludes.
//
// state      | meaning
// AWAITSTART | idle, waiting for Start press (code 0)
// PLAYING    | playfield enabled (code 1)
// PAUSED     | play frozen until Pause press (code 2)
// DYING      | respawn delay after a death (code 3)
// LEVELUP    | level-up interlude after reaching home (code 4)
// ENDGAME    | no lives left, wait for Start/Restart (code 5)
module sc_game_flow_fsm #(
    parameter int STATE_DATAWIDTH = 3,
    parameter int LIVES           = 3,
    parameter int LIVES_WIDTH     = 2,
    parameter int LEVEL_WIDTH     = 4,
    parameter int MAX_LEVEL       = 9,
    parameter int RESPAWN_TICKS   = 32,
    parameter int LEVELUP_TICKS   = 64,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                       SC_GAME_FLOW_FSM_CLOCK_50,
    input  logic                       SC_GAME_FLOW_FSM_RESET_InLow,
    input  logic                       SC_GAME_FLOW_FSM_StartSignal_InLow,
    input  logic                       SC_GAME_FLOW_FSM_PauseSignal_InLow,
    input  logic                       SC_GAME_FLOW_FSM_RestartSignal_InLow,
    input  logic                       SC_GAME_FLOW_FSM_Death_In,
    input  logic                       SC_GAME_FLOW_FSM_Goal_In,
    input  logic                       SC_GAME_FLOW_FSM_Tick_In,
    output logic [STATE_DATAWIDTH-1:0] SC_GAME_FLOW_FSM_CurrentState_Out,
    output logic                       SC_GAME_FLOW_FSM_LoadSignal_out,
    output logic [LIVES_WIDTH-1:0]     SC_GAME_FLOW_FSM_Lives_Out,
    output logic [LEVEL_WIDTH-1:0]     SC_GAME_FLOW_FSM_Level_Out,
    output logic                       SC_GAME_FLOW_FSM_Respawn_Out,
    output logic                       SC_GAME_FLOW_FSM_GameOver_Out
);

    typedef enum logic [2:0] {
        AWAITSTART = 3'd0,
        PLAYING    = 3'd1,
        PAUSED     = 3'd2,
        DYING      = 3'd3,
        LEVELUP    = 3'd4,
        ENDGAME    = 3'd5
    } state_t;

    state_t                 state_q, state_n;
    logic [LIVES_WIDTH-1:0] lives_q, lives_n;
    logic [LEVEL_WIDTH-1:0] level_q, level_n;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_n;
    logic                   respawn_q, respawn_n;
    logic                   start_prev, pause_prev, restart_prev;
    logic                   armed_q;
    logic                   start_press, pause_press, restart_press;

    // armed_q masks the first cycle after reset so a button held through reset
    // is seen as already low rather than as a fresh press.
    assign start_press   = armed_q & start_prev   & ~SC_GAME_FLOW_FSM_StartSignal_InLow;
    assign pause_press   = armed_q & pause_prev   & ~SC_GAME_FLOW_FSM_PauseSignal_InLow;
    assign restart_press = armed_q & restart_prev & ~SC_GAME_FLOW_FSM_RestartSignal_InLow;

    always_ff @(posedge SC_GAME_FLOW_FSM_CLOCK_50 or negedge SC_GAME_FLOW_FSM_RESET_InLow) begin
        if (!SC_GAME_FLOW_FSM_RESET_InLow) begin
            state_q      <= AWAITSTART;
            lives_q      <= LIVES_WIDTH'(LIVES);
            level_q      <= LEVEL_WIDTH'(1);
            cnt_q        <= '0;
            respawn_q    <= 1'b0;
            start_prev   <= 1'b1;
            pause_prev   <= 1'b1;
            restart_prev <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            lives_q      <= lives_n;
            level_q      <= level_n;
            cnt_q        <= cnt_n;
            respawn_q    <= respawn_n;
            start_prev   <= SC_GAME_FLOW_FSM_StartSignal_InLow;
            pause_prev   <= SC_GAME_FLOW_FSM_PauseSignal_InLow;
            restart_prev <= SC_GAME_FLOW_FSM_RestartSignal_InLow;
            armed_q      <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state_q;
        lives_n   = lives_q;
        level_n   = level_q;
        cnt_n     = cnt_q;
        respawn_n = 1'b0;
        case (state_q)
            AWAITSTART: begin
                if (start_press) begin
                    state_n   = PLAYING;
                    lives_n   = LIVES_WIDTH'(LIVES);
                    level_n   = LEVEL_WIDTH'(1);
                    respawn_n = 1'b1;
                end
            end
            PLAYING: begin
                if (restart_press) begin
                    state_n = AWAITSTART;
                end else if (SC_GAME_FLOW_FSM_Death_In) begin
                    state_n = DYING;
                    lives_n = lives_q - LIVES_WIDTH'(1);
                    cnt_n   = '0;
                end else if (SC_GAME_FLOW_FSM_Goal_In) begin
                    state_n = LEVELUP;
                    cnt_n   = '0;
                end else if (pause_press) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (restart_press) begin
                    state_n = AWAITSTART;
                end else if (pause_press) begin
                    state_n = PLAYING;
                end
            end
            DYING: begin
                if (restart_press) begin
                    state_n = AWAITSTART;
                end else if (SC_GAME_FLOW_FSM_Tick_In) begin
                    if (cnt_q == CNT_WIDTH'(RESPAWN_TICKS - 1)) begin
                        if (lives_q == '0) begin
                            state_n = ENDGAME;
                        end else begin
                            state_n   = PLAYING;
                            respawn_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            LEVELUP: begin
                if (restart_press) begin
                    state_n = AWAITSTART;
                end else if (SC_GAME_FLOW_FSM_Tick_In) begin
                    if (cnt_q == CNT_WIDTH'(LEVELUP_TICKS - 1)) begin
                        state_n   = PLAYING;
                        respawn_n = 1'b1;
                        if (level_q < LEVEL_WIDTH'(MAX_LEVEL)) begin
                            level_n = level_q + LEVEL_WIDTH'(1);
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ENDGAME: begin
                if (restart_press || start_press) begin
                    state_n = AWAITSTART;
                end
            end
            default: state_n = AWAITSTART;
        endcase
    end

    assign SC_GAME_FLOW_FSM_CurrentState_Out = STATE_DATAWIDTH'(state_q);
    assign SC_GAME_FLOW_FSM_LoadSignal_out   = (state_q == PLAYING);
    assign SC_GAME_FLOW_FSM_GameOver_Out     = (state_q == ENDGAME);
    assign SC_GAME_FLOW_FSM_Lives_Out        = lives_q;
    assign SC_GAME_FLOW_FSM_Level_Out        = level_q;
    assign SC_GAME_FLOW_FSM_Respawn_Out      = respawn_q;

endmodule

// File: tb/tb_sc_game_flow_fsm.sv
// Directed table-driven bench for sc_game_flow_fsm with hand-computed expectations
// plus hand sequences for reset-with-button-held, the level loop and async reset.
module tb_sc_game_flow_fsm;

    logic       clk;
    logic       rst_n;
    logic       start_b, pause_b, restart_b;
    logic       death, goal, tick;
    logic [2:0] cur_state;
    logic       load;
    logic [1:0] lives;
    logic [3:0] level;
    logic       respawn;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    sc_game_flow_fsm #(
        .STATE_DATAWIDTH(3), .LIVES(3), .LIVES_WIDTH(2), .LEVEL_WIDTH(4),
        .MAX_LEVEL(9), .RESPAWN_TICKS(32), .LEVELUP_TICKS(64), .CNT_WIDTH(8)
    ) dut (
        .SC_GAME_FLOW_FSM_CLOCK_50           (clk),
        .SC_GAME_FLOW_FSM_RESET_InLow        (rst_n),
        .SC_GAME_FLOW_FSM_StartSignal_InLow  (start_b),
        .SC_GAME_FLOW_FSM_PauseSignal_InLow  (pause_b),
        .SC_GAME_FLOW_FSM_RestartSignal_InLow(restart_b),
        .SC_GAME_FLOW_FSM_Death_In           (death),
        .SC_GAME_FLOW_FSM_Goal_In            (goal),
        .SC_GAME_FLOW_FSM_Tick_In            (tick),
        .SC_GAME_FLOW_FSM_CurrentState_Out   (cur_state),
        .SC_GAME_FLOW_FSM_LoadSignal_out     (load),
        .SC_GAME_FLOW_FSM_Lives_Out          (lives),
        .SC_GAME_FLOW_FSM_Level_Out          (level),
        .SC_GAME_FLOW_FSM_Respawn_Out        (respawn),
        .SC_GAME_FLOW_FSM_GameOver_Out       (game_over)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Buttons are raw levels (0 = pressed); rep = cycles the inputs are held before checking.
    typedef struct {
        logic st, pa, rs, de, go, tk;
        int   rep;
        int   e_state;
        int   e_load;
        int   e_lives;
        int   e_level;
        int   e_resp;
        int   e_gover;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic pa, logic rs, logic de, logic go, logic tk,
                                int rep, int s, int ld, int lv, int lvl, int rp, int gv);
        vec_t v;
        v.st = st; v.pa = pa; v.rs = rs; v.de = de; v.go = go; v.tk = tk;
        v.rep = rep; v.e_state = s; v.e_load = ld; v.e_lives = lv;
        v.e_level = lvl; v.e_resp = rp; v.e_gover = gv;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic pa, input logic rs,
                         input logic de, input logic go, input logic tk, input int rep);
        for (int c = 0; c < rep; c++) begin
            @(negedge clk);
            start_b = st; pause_b = pa; restart_b = rs;
            death = de; goal = go; tick = tk;
            @(posedge clk);
        end
        #1;
    endtask

    task automatic check_all(input string tag, input int s, input int ld, input int lv,
                             input int lvl, input int rp, input int gv);
        chk({tag, " state"},    int'(cur_state), s);
        chk({tag, " load"},     int'(load),      ld);
        chk({tag, " lives"},    int'(lives),     lv);
        chk({tag, " level"},    int'(level),     lvl);
        chk({tag, " respawn"},  int'(respawn),   rp);
        chk({tag, " gameover"}, int'(game_over), gv);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive(v.st, v.pa, v.rs, v.de, v.go, v.tk, v.rep);
        check_all($sformatf("v%0d", i), v.e_state, v.e_load, v.e_lives,
                  v.e_level, v.e_resp, v.e_gover);
    endtask

    int n_part_a;
    int exp_lvl;

    initial begin
        //            st pa rs de go tk rep  st ld lv lvl rp go
        // start held through reset, then first game, deaths down to ENDGAME
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 3,  0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1,  3, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 31, 3, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1,  1, 1, 2, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1,  3, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 32, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1,  3, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 32, 5, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 2,  5, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 0, 0));
        n_part_a = vecs.size();
        // after the level loop: death beats goal, restart keeps counters, pause, ignored ticks
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 3, 9, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1,  3, 0, 2, 9, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1,  0, 0, 2, 9, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  0, 0, 2, 9, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1,  2, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  2, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 1, 3,  2, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 1,  2, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 1,  4, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1,  0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1,  0, 0, 3, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1,  1, 1, 3, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 5,  1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1,  3, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 31, 3, 0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1,  1, 1, 2, 1, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1,  3, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 10, 3, 0, 1, 1, 0, 0));

        rst_n = 1'b0;
        start_b = 1'b0; pause_b = 1'b1; restart_b = 1'b1;
        death = 1'b0; goal = 1'b0; tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 3, 1, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n_part_a; i++) run_vec(i);

        // ten level-ups: level climbs 2..9 and then saturates at 9
        for (int g = 1; g <= 10; g++) begin
            exp_lvl = (g + 1 > 9) ? 9 : g + 1;
            drive(1, 1, 1, 0, 1, 0, 1);
            check_all($sformatf("goal%0d enter", g), 4, 0, 3, exp_lvl == 2 ? 1 : exp_lvl - (g + 1 > 9 ? 0 : 1), 0, 0);
            drive(1, 1, 1, 0, 0, 1, 63);
            chk($sformatf("goal%0d tick63 state", g), int'(cur_state), 4);
            drive(1, 1, 1, 0, 0, 1, 1);
            check_all($sformatf("goal%0d expire", g), 1, 1, 3, exp_lvl, 1, 0);
        end

        for (int i = n_part_a; i < vecs.size(); i++) run_vec(i);

        // asynchronous reset mid-DYING takes effect without a clock edge
        @(negedge clk);
        death = 1'b0; tick = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 3, 1, 0, 0);
        #20;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_game_flow_fsm.md
Name: sc_game_flow_fsm

Overview:
Parametrised main game-flow controller for the Frogger datapath. It supersedes the three-state start/play/end controller with six states: pause, a timed respawn after a death, a timed level-up interlude, and a lives counter and level counter. It sits between the debounced button/collision logic and the playfield, enabling and loading it through LoadSignal_out and reporting state, lives and level to the scoreboard and display blocks.

Parameters:
STATE_DATAWIDTH, 3, width of CurrentState_Out (≥3)
LIVES, 3, lives at game start (≥1)
LIVES_WIDTH, 2, width of lives counter (must hold LIVES)
LEVEL_WIDTH, 4, width of level counter
MAX_LEVEL, 9, level saturation value (≥1, < 2^LEVEL_WIDTH)
RESPAWN_TICKS, 32, Tick strobes spent in DYING (≥1)
LEVELUP_TICKS, 64, Tick strobes spent in LEVELUP (≥1)
CNT_WIDTH, 8, delay-counter width (must hold max of the two tick counts)

Ports:
SC_GAME_FLOW_FSM_CLOCK_50  in  1  system clock, 50 MHz
SC_GAME_FLOW_FSM_RESET_InLow  in  1  asynchronous active-low reset
SC_GAME_FLOW_FSM_StartSignal_InLow  in  1  start button, low = pressed (synchronised upstream)
SC_GAME_FLOW_FSM_PauseSignal_InLow  in  1  pause button, low = pressed
SC_GAME_FLOW_FSM_RestartSignal_InLow  in  1  restart button, low = pressed
SC_GAME_FLOW_FSM_Death_In  in  1  1-cycle strobe, frog hit or drowned
SC_GAME_FLOW_FSM_Goal_In  in  1  1-cycle strobe, frog reached home row
SC_GAME_FLOW_FSM_Tick_In  in  1  1-cycle frame/time-base strobe
SC_GAME_FLOW_FSM_CurrentState_Out  out  STATE_DATAWIDTH  state code
SC_GAME_FLOW_FSM_LoadSignal_out  out  1  playfield enable
SC_GAME_FLOW_FSM_Lives_Out  out  LIVES_WIDTH  remaining lives
SC_GAME_FLOW_FSM_Level_Out  out  LEVEL_WIDTH  current level
SC_GAME_FLOW_FSM_Respawn_Out  out  1  1-cycle pulse, reposition frog
SC_GAME_FLOW_FSM_GameOver_Out  out  1  high in ENDGAME

Behaviour:
- Clock: one clock. Reset: asynchronous, active-low.
- State codes: AWAITSTART=0, PLAYING=1, PAUSED=2, DYING=3, LEVELUP=4, ENDGAME=5. Codes 6 and 7 are illegal; an illegal code moves to AWAITSTART on the next clock.
- Reset values: state=AWAITSTART, Lives=LIVES, Level=1, delay counter=0, Respawn=0, GameOver=0, LoadSignal=0.
- Button edge registers reset to 1, so a button held through reset does not produce a press.
- Button press: a button's registered previous value is 1 and its current value is 0. The press is valid for exactly one cycle.
- AWAITSTART:
  - Start press → PLAYING.
  - Lives<=LIVES, Level<=1, Respawn pulse.
- PLAYING, priority Restart > Death > Goal > Pause:
  - Restart press → AWAITSTART.
  - Death → DYING, Lives<=Lives-1.
  - Goal → LEVELUP.
  - Pause press → PAUSED.
- PAUSED:
  - Restart press → AWAITSTART.
  - Pause press → PLAYING.
  - Death and Goal are ignored.
- DYING:
  - Counter clears on entry and increments on each Tick.
  - On the Tick where counter==RESPAWN_TICKS-1: if Lives==0 → ENDGAME, else → PLAYING with Respawn pulse.
  - Restart press → AWAITSTART, taking priority over expiry.
- LEVELUP:
  - Same timing, using LEVELUP_TICKS.
  - Expiry → PLAYING, Respawn pulse, Level<=Level+1, saturating at MAX_LEVEL.
  - Restart press → AWAITSTART.
- ENDGAME: Restart press or Start press → AWAITSTART.
- Counter rules:
  - Lives never underflows; decrement only occurs from PLAYING, where Lives≥1.
  - Ticks arriving outside DYING and LEVELUP are ignored.
- Outputs:
  - LoadSignal_out=1 only in PLAYING; combinational decode of the state register.
  - GameOver_Out=1 only in ENDGAME.
  - CurrentState_Out = state register.
  - Respawn_Out is registered and asserts in the first cycle of the new PLAYING state.
- Entering AWAITSTART by restart leaves Lives and Level unchanged until the next Start press. Asserting reset at any point restores all reset values immediately.

Test Plan:
- Reset low with Start held low, release reset, keep Start low → stays AWAITSTART (0), Lives=3, Level=1, LoadSignal=0.
- Start press → state 1 one clock later, LoadSignal=1, Respawn high for exactly 1 cycle.
- Death in PLAYING → state 3, Lives=2. After 32 Ticks → state 1 and Respawn pulse. Fewer than 32 Ticks → stays 3.
- Three deaths with Ticks → after the third DYING expiry state=5, GameOver=1, Lives=0. Restart press → state 0.
- Goal in PLAYING ×10 with 64 Ticks each → Level increments 1..9 and holds at 9. Death and Goal in the same cycle → DYING wins, Level unchanged.
- Pause press → state 2, LoadSignal=0. Death and Tick in PAUSED have no effect. Second Pause press → state 1. Reset low mid-DYING → state 0, Lives=3 at once.
